icache_responder: RTL and testbench

- Direct-mapped instruction cache on the IFetcher's icache interface.
- Serves IFetcher fetch requests (enable + pc) with a same-cycle combinational hit response (valid + inst).
- On a miss, runs a word-by-word line fill from the memory controller over a req/valid handshake.
- Sits between the IFetcher and mem_ctrl; read-only, with no write or invalidate path from the core.

---
 rtl/icache_responder.sv | 147 ++++++++++++++
 tb/tb_icache_responder.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_responder.sv
// Direct-mapped read-only instruction cache with word-by-word line fill.
// Define ICACHE_STAT_EN to add hit_count/miss_count statistics outputs.
module icache_responder #(
  parameter int INDEX_WIDTH  = 6,
  parameter int OFFSET_WIDTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        fetch_enable,
  input  logic [31:0] fetch_pc,
  output logic        fetch_valid,
  output logic [31:0] fetch_inst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_valid,
  input  logic [31:0] mem_data
`ifdef ICACHE_STAT_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int LINES   = 1 << INDEX_WIDTH;
  localparam int WORDS   = 1 << OFFSET_WIDTH;
  localparam int LSB_W   = OFFSET_WIDTH + 2;
  localparam int TAG_LSB = INDEX_WIDTH + LSB_W;
  localparam int TAG_W   = 32 - TAG_LSB;
  localparam int CNT_W   = OFFSET_WIDTH + 1;

  typedef enum logic {
    IDLE,
    FILL
  } state_t;

  state_t state_q, state_d;

  logic [LINES-1:0]       valid_q;
  logic [TAG_W-1:0]       tag_q  [LINES];
  logic [31:0]            data_q [LINES][WORDS];
  logic [INDEX_WIDTH-1:0] fill_idx_q;
  logic [TAG_W-1:0]       fill_tag_q;
  logic [CNT_W-1:0]       cnt_q;

  logic [OFFSET_WIDTH-1:0] pc_off;
  logic [INDEX_WIDTH-1:0]  pc_idx;
  logic [TAG_W-1:0]        pc_tag;
  logic                    hit;
  logic                    start_fill;
  logic                    word_in;
  logic                    last_word;
  logic                    unused_ok;

  assign pc_off    = fetch_pc[LSB_W-1:2];
  assign pc_idx    = fetch_pc[TAG_LSB-1:LSB_W];
  assign pc_tag    = fetch_pc[31:TAG_LSB];
  assign unused_ok = ^fetch_pc[1:0];

  assign hit = fetch_enable & valid_q[pc_idx]
             & (tag_q[pc_idx] == pc_tag);

  assign fetch_valid = hit;
  assign fetch_inst  = hit ? data_q[pc_idx][pc_off] : '0;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Misses seen during FILL are not latched; the fetcher re-presents them.
  always_comb begin
    state_d    = state_q;
    start_fill = 1'b0;
    word_in    = 1'b0;
    last_word  = 1'b0;
    if (rdy) begin
      unique case (state_q)
        IDLE: begin
          if (fetch_enable & ~hit) begin
            start_fill = 1'b1;
            state_d    = FILL;
          end
        end
        FILL: begin
          if (mem_valid) begin
            word_in = 1'b1;
            if (cnt_q == CNT_W'(WORDS - 1)) begin
              last_word = 1'b1;
              state_d   = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= '0;
      cnt_q      <= '0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      fill_idx_q <= '0;
      fill_tag_q <= '0;
    end else begin
      if (start_fill) begin
        valid_q[pc_idx] <= 1'b0;
        fill_idx_q      <= pc_idx;
        fill_tag_q      <= pc_tag;
        cnt_q           <= '0;
        mem_req         <= 1'b1;
        mem_addr        <= {fetch_pc[31:LSB_W], LSB_W'(0)};
      end
      if (word_in) begin
        cnt_q    <= cnt_q + 1'b1;
        mem_addr <= mem_addr + 32'd4;
      end
      if (last_word) begin
        valid_q[fill_idx_q] <= 1'b1;
        mem_req             <= 1'b0;
      end
    end
  end

  // Tag/data storage carries no reset so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (!rst && word_in)
      data_q[fill_idx_q][cnt_q[OFFSET_WIDTH-1:0]] <= mem_data;
    if (!rst && last_word)
      tag_q[fill_idx_q] <= fill_tag_q;
  end

`ifdef ICACHE_STAT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (rdy & hit)  hit_count  <= hit_count + 32'd1;
      if (start_fill) miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_responder.sv
// Directed bench for icache_responder with a queue of expected fill addresses.
// Stat counters are checked when ICACHE_STAT_EN is defined.
module tb_icache_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        fetch_enable;
  logic [31:0] fetch_pc;
  logic        fetch_valid;
  logic [31:0] fetch_inst;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_valid;
  logic [31:0] mem_data;
`ifdef ICACHE_STAT_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  icache_responder dut (
    .clk          (clk),
    .rst          (rst),
    .rdy          (rdy),
    .fetch_enable (fetch_enable),
    .fetch_pc     (fetch_pc),
    .fetch_valid  (fetch_valid),
    .fetch_inst   (fetch_inst),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_valid    (mem_valid),
    .mem_data     (mem_data)
`ifdef ICACHE_STAT_EN
    ,
    .hit_count    (hit_count),
    .miss_count   (miss_count)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] memval(input logic [31:0] a);
    case (a)
      32'h40:  return 32'h11;
      32'h44:  return 32'h22;
      32'h48:  return 32'h33;
      32'h4C:  return 32'h44;
      default: return 32'hC0DE_0000 ^ a;
    endcase
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  // Present a missing pc, queue the line's word addresses, check first request.
  task automatic miss(input logic [31:0] pc);
    logic [31:0] base;
    base = {pc[31:4], 4'h0};
    fetch_enable = 1'b1;
    fetch_pc = pc;
    #1;
    chk("miss_valid", 32'(fetch_valid), 32'd0);
    for (int i = 0; i < 4; i++) exp_q.push_back(base + 32'(4 * i));
    step();
    chk("first_req", 32'(mem_req), 32'd1);
    chk("first_addr", mem_addr, base);
  endtask

  task automatic serve(input int n);
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      int t = 0;
      while (mem_req !== 1'b1 && t < 20) begin
        step();
        t++;
      end
      chk("req_wait", 32'(mem_req), 32'd1);
      if (exp_q.size() == 0) begin
        chk("queue_empty", 32'(exp_q.size()), 32'd1);
        a = 32'hFFFF_FFFF;
      end else begin
        a = exp_q.pop_front();
      end
      chk("mem_addr", mem_addr, a);
      mem_valid = 1'b1;
      mem_data = memval(a);
      step();
      mem_valid = 1'b0;
      mem_data = '0;
      if (i != n - 1) step();
    end
  endtask

  task automatic hitchk(input logic [31:0] pc, input logic [31:0] exp);
    fetch_enable = 1'b1;
    fetch_pc = pc;
    #1;
    chk("hit_valid", 32'(fetch_valid), 32'd1);
    chk("hit_inst", fetch_inst, exp);
  endtask

  initial begin
    rst = 1'b1;
    rdy = 1'b1;
    fetch_enable = 1'b0;
    fetch_pc = '0;
    mem_valid = 1'b0;
    mem_data = '0;
    step();
    step();
    rst = 1'b0;
    #1;
    chk("rst_fetch_valid", 32'(fetch_valid), 32'd0);
    chk("rst_fetch_inst", fetch_inst, 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);

    // cold miss on 0x40
    miss(32'h40);
    serve(4);
    #1;
    chk("cold_valid", 32'(fetch_valid), 32'd1);
    chk("cold_inst", fetch_inst, 32'h11);
    chk("cold_req_drop", 32'(mem_req), 32'd0);

    // same-line hits
    hitchk(32'h4C, 32'h44);
    hitchk(32'h48, 32'h33);
    step();
    chk("hit_no_req", 32'(mem_req), 32'd0);

    // mem_valid while idle is ignored
    fetch_enable = 1'b0;
    mem_valid = 1'b1;
    mem_data = 32'hDEAD_BEEF;
    step();
    mem_valid = 1'b0;
    step();
    chk("idle_mv_req", 32'(mem_req), 32'd0);
    hitchk(32'h40, 32'h11);

    // hit-under-fill
    miss(32'h80);
    serve(2);
    hitchk(32'h44, 32'h22);
    chk("huf_req", 32'(mem_req), 32'd1);
    fetch_pc = 32'h80;
    #1;
    chk("huf_fill_line", 32'(fetch_valid), 32'd0);
    serve(2);
    hitchk(32'h80, memval(32'h80));
    hitchk(32'h8C, memval(32'h8C));

    // conflict on index 4
    miss(32'h440);
    serve(4);
    hitchk(32'h440, memval(32'h440));
    hitchk(32'h448, memval(32'h448));
    miss(32'h40);
    serve(4);
    hitchk(32'h40, 32'h11);

    // rdy stall mid-fill with mem_valid asserted
    miss(32'h300);
    serve(1);
    rdy = 1'b0;
    mem_valid = 1'b1;
    mem_data = 32'hBAD0_0000;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_addr", mem_addr, 32'h304);
      chk("stall_req", 32'(mem_req), 32'd1);
    end
    rdy = 1'b1;
    mem_valid = 1'b0;
    mem_data = '0;
    step();
    chk("stall_after", mem_addr, 32'h304);
    serve(3);
    hitchk(32'h304, memval(32'h304));
    hitchk(32'h30C, memval(32'h30C));

    // reset mid-fill
    miss(32'h100);
    serve(2);
    rst = 1'b1;
    step();
    chk("rstfill_req", 32'(mem_req), 32'd0);
    chk("rstfill_addr", mem_addr, 32'd0);
    rst = 1'b0;
    exp_q.delete();
    fetch_pc = 32'h100;
    #1;
    chk("rstfill_abandon", 32'(fetch_valid), 32'd0);
    miss(32'h40);
    serve(4);
    hitchk(32'h40, 32'h11);

`ifdef ICACHE_STAT_EN
    fetch_enable = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("stat_rst_hit", hit_count, 32'd0);
    chk("stat_rst_miss", miss_count, 32'd0);
    miss(32'h40);
    serve(4);
    fetch_enable = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      fetch_enable = 1'b1;
      fetch_pc = 32'h44;
      step();
    end
    fetch_enable = 1'b0;
    step();
    chk("stat_hit", hit_count, 32'd5);
    chk("stat_miss", miss_count, 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
